// File: rtl/knn_dist_core.sv
// knn_dist_core: saturating squared Euclidean distance between two points, gated by a registered enable
module knn_dist_core #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                KNN_ENABLE,
  input  logic [DATA_W/2-1:0] x1,
  input  logic [DATA_W/2-1:0] x2,
  input  logic [DATA_W/2-1:0] y1,
  input  logic [DATA_W/2-1:0] y2,
  output logic [DATA_W-1:0]   z
);
  localparam int H = DATA_W / 2;
  logic              en_r;
  logic [H-1:0]      dx, dy;
  logic [DATA_W-1:0] dxe, dye, dx2, dy2;
  logic [DATA_W:0]   sq;
  always_ff @(posedge clk or posedge rst)
    if (rst) en_r <= 1'b0;
    else     en_r <= KNN_ENABLE;
  always_comb begin
    dx  = (x1 > x2) ? x1 - x2 : x2 - x1;
    dy  = (y1 > y2) ? y1 - y2 : y2 - y1;
    dxe = {{H{1'b0}}, dx};
    dye = {{H{1'b0}}, dy};
    dx2 = dxe * dxe;
    dy2 = dye * dye;
    // one extra bit keeps the carry so overflow can saturate instead of wrap
    sq  = {1'b0, dx2} + {1'b0, dy2};
    z   = !en_r ? '0 : sq[DATA_W] ? '1 : sq[DATA_W-1:0];
  end
endmodule

// File: tb/tb_knn_dist_core.sv
// tb_knn_dist_core: scoreboard bench for knn_dist_core with a plain-arithmetic reference model
module tb_knn_dist_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        KNN_ENABLE = 1'b0;
  logic [15:0] x1 = '0, x2 = '0, y1 = '0, y2 = '0;
  logic [31:0] z;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  knn_dist_core #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .KNN_ENABLE(KNN_ENABLE),
    .x1(x1), .x2(x2), .y1(y1), .y2(y2), .z(z)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_dist(longint a, longint b, longint c, longint d);
    longint s;
    s = (a - b) * (a - b) + (c - d) * (c - d);
    return (s >= 64'h1_0000_0000) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // One transaction per cycle: enable seen at this edge decides whether z is live.
  task automatic apply(input string tag, input logic r, input logic en,
                       input int a, input int b, input int c, input int d);
    logic en_model;
    @(posedge clk);
    en_model = !rst && KNN_ENABLE;
    #1;
    rst = r; KNN_ENABLE = en;
    x1 = a[15:0]; x2 = b[15:0]; y1 = c[15:0]; y2 = d[15:0];
    if (r) en_model = 1'b0;
    exp_q.push_back(en_model ? ref_dist(longint'(a[15:0]), longint'(b[15:0]),
                                        longint'(c[15:0]), longint'(d[15:0])) : 32'h0);
    tag_q.push_back(tag);
  endtask

  always @(negedge clk)
    if (exp_q.size() > 0) begin
      logic [31:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (z !== e) begin
        bad++;
        $display("FAIL %s: z=%0d (0x%h) expected %0d (0x%h)", t, z, z, e, e);
      end
    end

  initial begin
    for (int i = 0; i < 3; i++)
      apply("reset_held", 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom);
    for (int i = 0; i < 3; i++)
      apply("released_disabled", 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom);
    apply("enable_first_cycle", 1'b0, 1'b1, 1, 4, 8, 3);
    apply("basic_34", 1'b0, 1'b1, 1, 4, 8, 3);
    apply("basic_1044", 1'b0, 1'b1, 3, 15, 20, 50);
    apply("basic_404185", 1'b0, 1'b1, 132, 33, 640, 12);
    apply("identical", 1'b0, 1'b1, 500, 500, 7, 7);
    apply("swapped_34", 1'b0, 1'b1, 4, 1, 3, 8);
    apply("saturate", 1'b0, 1'b1, 0, 65535, 0, 65535);
    apply("max_single_axis", 1'b0, 1'b1, 0, 65535, 0, 0);
    apply("enable_drop_edge", 1'b0, 1'b0, 9, 2, 5, 1);
    apply("enable_dropped", 1'b0, 1'b0, 9, 2, 5, 1);
    apply("reenable", 1'b0, 1'b1, 9, 2, 5, 1);
    apply("reenabled", 1'b0, 1'b1, 9, 2, 5, 1);
    apply("rst_mid_run", 1'b1, 1'b1, 9, 2, 5, 1);
    apply("rst_release", 1'b0, 1'b1, 9, 2, 5, 1);
    apply("after_release", 1'b0, 1'b1, 9, 2, 5, 1);
    for (int i = 0; i < 300; i++) begin
      int a, b, c, d;
      a = (i % 4 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 65535);
      b = (i % 4 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 65535);
      c = $urandom_range(0, 65535);
      d = (i % 5 == 0) ? c : $urandom_range(0, 65535);
      if (i % 3 == 0) apply("rand_swapped", ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0), b, a, d, c);
      else apply("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0), a, b, c, d);
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
